// File: rtl/poli_fetch_unit.sv
// poli_fetch_unit: instruction fetch with credit-limited memory requests, PC-tagged FIFO and redirect squash.
// Optional FETCH_MISALIGN_EN adds a sticky fetch_misalign flag for redirects to non-word-aligned targets.
module poli_fetch_unit #(
    parameter int W = 32,
    parameter int DEPTH = 4,
    parameter int MAX_OUT = 2,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_valid,
    input  logic [W-1:0] redirect_pc,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [W-1:0] imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [W-1:0] imem_rsp_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [W-1:0] inst_data,
    output logic [W-1:0] inst_pc,
`ifdef FETCH_MISALIGN_EN
    output logic         fetch_misalign,
`endif
    output logic         flushing
);
    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int SW = CW + AW + 1;

    logic [W-1:0]  fetch_pc, rsp_pc, target_pc;
    logic [CW-1:0] outstanding, drop_cnt;
    logic [AW:0]   wr_ptr, rd_ptr, fifo_count;
    logic [W-1:0]  fifo_data [DEPTH];
    logic [W-1:0]  fifo_pc [DEPTH];
    logic [SW-1:0] credit_use;
    logic          fire, push, pop, dropping;

    // Responses still owed to the FIFO plus what it already holds must fit in DEPTH.
    assign fifo_count = wr_ptr - rd_ptr;
    assign credit_use = SW'(outstanding - drop_cnt) + SW'(fifo_count);
    assign imem_req_valid = rst && !redirect_valid && outstanding < CW'(MAX_OUT) && credit_use < SW'(DEPTH);
    assign imem_req_addr = fetch_pc;
    assign fire = imem_req_valid && imem_req_ready;
    assign dropping = drop_cnt != '0;
    assign flushing = dropping;
    assign push = imem_rsp_valid && !dropping && !redirect_valid;
    assign inst_valid = fifo_count != '0;
    assign pop = inst_valid && inst_ready && !redirect_valid;
    assign inst_data = fifo_data[rd_ptr[AW-1:0]];
    assign inst_pc = fifo_pc[rd_ptr[AW-1:0]];
    assign target_pc = redirect_pc & ~W'(3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc <= target_pc;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (fire)
                    fetch_pc <= fetch_pc + W'(4);
                if (imem_rsp_valid && dropping)
                    drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    fifo_data[wr_ptr[AW-1:0]] <= imem_rsp_data;
                    fifo_pc[wr_ptr[AW-1:0]] <= rsp_pc;
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                    rsp_pc <= rsp_pc + W'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fetch_misalign <= 1'b0;
        else if (redirect_valid && redirect_pc[1:0] != 2'b00)
            fetch_misalign <= 1'b1;
    end
`endif

    // A response with nothing outstanding or a push into a full FIFO means the credit logic is broken.
    assert property (@(posedge clk) disable iff (!rst) imem_rsp_valid |-> outstanding != '0);
    assert property (@(posedge clk) disable iff (!rst) (push && !pop) |-> fifo_count != (AW+1)'(DEPTH));
endmodule

// File: tb/tb_poli_fetch_unit.sv
// tb_poli_fetch_unit: directed and random fetch traffic against a queue-based memory and stream model.
module tb_poli_fetch_unit;
    localparam int DEPTH = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        flushing;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_misalign;
`endif

    poli_fetch_unit dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
`ifdef FETCH_MISALIGN_EN
        .fetch_misalign(fetch_misalign),
`endif
        .flushing(flushing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mq[$];
    logic [31:0] fire_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_fetch, exp_pc;
    int          buf_n, lat, cyc, n_checks, n_fail, p0;
    bit          mis_exp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, advance the model, move to the next edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit irdy, input bit qrdy);
        bit   rv, stale_any, fired;
        int   nonstale;
        req_t r;
        rv = mq.size() > 0 && mq[0].due <= cyc;
        redirect_valid = redir;
        redirect_pc = rpc;
        inst_ready = irdy;
        imem_req_ready = qrdy;
        imem_rsp_valid = rv;
        imem_rsp_data = rv ? mem_word(mq[0].addr) : $urandom;
        #1;
        stale_any = 0;
        nonstale = 0;
        foreach (mq[i]) begin
            if (mq[i].stale) stale_any = 1;
            else nonstale++;
        end
        chk("flushing", flushing, stale_any);
        chk("inst_valid", inst_valid, buf_n > 0);
        chk("req_valid", imem_req_valid, !redir && mq.size() < MAX_OUT && nonstale + buf_n < DEPTH);
`ifdef FETCH_MISALIGN_EN
        chk("misalign", fetch_misalign, mis_exp);
        if (redir && rpc[1:0] != 2'b00) mis_exp = 1;
`endif
        fired = imem_req_valid && qrdy;
        if (inst_valid && irdy && !redir) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, mem_word(exp_pc));
            pop_log.push_back(inst_pc);
            exp_pc += 4;
            buf_n--;
        end
        if (rv) begin
            r = mq.pop_front();
            if (!r.stale && !redir) buf_n++;
        end
        if (redir) begin
            foreach (mq[i]) mq[i].stale = 1;
            exp_fetch = rpc & ~32'h3;
            exp_pc = rpc & ~32'h3;
            buf_n = 0;
        end
        if (fired) begin
            chk("req_addr", imem_req_addr, exp_fetch);
            fire_log.push_back(imem_req_addr);
            mq.push_back('{exp_fetch, cyc + lat, 1'b0});
            exp_fetch += 4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        mq.delete();
        fire_log.delete();
        pop_log.delete();
        exp_fetch = 32'h0;
        exp_pc = 32'h0;
        buf_n = 0;
        mis_exp = 0;
    endtask

    initial begin
        rst = 1'b0;
        redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0; inst_ready = 0;
        n_checks = 0; n_fail = 0; cyc = 0; lat = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_flushing", flushing, 0);
        rst = 1'b1;

        // Core stalled: exactly DEPTH words buffered, then drain and resume at 0x10.
        repeat (8) step(0, 0, 0, 1);
        chk("stall_fires", fire_log.size(), DEPTH);
        chk("stall_valid", inst_valid, 1);
        p0 = pop_log.size();
        repeat (4) step(0, 0, 1, 1);
        chk("drain_pops", pop_log.size() - p0, 4);
        chk("resume_addr", fire_log.size() > 4 ? fire_log[4] : 32'hx, 32'h10);
        chk("pop0", pop_log.size() > 2 ? pop_log[0] : 32'hx, 32'h0);
        chk("pop2", pop_log.size() > 2 ? pop_log[2] : 32'hx, 32'h8);

        // Sustained one instruction per cycle with 1-cycle memory.
        repeat (10) step(0, 0, 1, 1);
        p0 = pop_log.size();
        repeat (10) step(0, 0, 1, 1);
        chk("sustained", pop_log.size() - p0, 10);

        // Latency 3: redirect with two requests in flight, neither responding this cycle.
        lat = 3;
        for (int t = 0; t < 20 && !(mq.size() == 2 && mq[0].due > cyc); t++) step(0, 0, 1, 1);
        chk("two_outstanding", mq.size(), 2);
        step(1, 32'h100, 1, 1);
        chk("flush_set", flushing, 1);
        for (int t = 0; t < 20 && flushing; t++) step(0, 0, 1, 1);
        chk("flush_done", flushing, 0);
        p0 = pop_log.size();
        for (int t = 0; t < 20 && pop_log.size() == p0; t++) step(0, 0, 1, 1);
        chk("first_after_redir", pop_log.size() > p0 ? pop_log[p0] : 32'hx, 32'h100);

        // Redirect in the same cycle as the only outstanding response.
        lat = 2;
        for (int t = 0; t < 20 && mq.size() != 0; t++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("single_out", mq.size(), 1);
        for (int t = 0; t < 20 && mq.size() == 1 && mq[0].due > cyc; t++) step(0, 0, 1, 0);
        step(1, 32'h100, 1, 0);
        chk("no_flush", flushing, 0);
        p0 = fire_log.size();
        for (int t = 0; t < 20 && fire_log.size() == p0; t++) step(0, 0, 1, 1);
        chk("redir_addr", fire_log.size() > p0 ? fire_log[p0] : 32'hx, 32'h100);

        // Misaligned redirect target is masked to the word address.
        step(1, 32'h102, 1, 1);
        p0 = fire_log.size();
        for (int t = 0; t < 20 && fire_log.size() == p0; t++) step(0, 0, 1, 1);
        chk("masked_addr", fire_log.size() > p0 ? fire_log[p0] : 32'hx, 32'h100);

        // Address wrap past the top of memory.
        lat = 1;
        step(1, 32'hFFFF_FFF8, 1, 1);
        repeat (8) step(0, 0, 1, 1);

        // Random traffic with random latency, back-pressure and redirects.
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) lat = $urandom_range(1, 4);
            step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset with the FIFO partly filled.
        lat = 1;
        for (int t = 0; t < 20 && mq.size() != 0; t++) step(0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1);
        chk("half_full", inst_valid, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_req_valid", imem_req_valid, 0);
        chk("arst_inst_valid", inst_valid, 0);
        chk("arst_inst_data", inst_data, 0);
        chk("arst_inst_pc", inst_pc, 0);
        chk("arst_flushing", flushing, 0);
`ifdef FETCH_MISALIGN_EN
        chk("arst_misalign", fetch_misalign, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step(0, 0, 1, 1);
        chk("post_rst_addr", fire_log.size() > 0 ? fire_log[0] : 32'hx, 32'h0);
        repeat (10) step(0, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/poli_fetch_unit.md
Name: poli_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the single-cycle core. Issues word fetches to the instruction memory over a valid/ready request channel and accepts in-order responses. Buffers fetched words with their PCs in a small FIFO and presents them to the core over a valid/ready handshake. Handles redirects (taken branch, jal, jalr) by flushing and squashing in-flight responses.

Parameters:
W, 32, data/address width
DEPTH, 4, instruction FIFO entries (power of two, >=2)
MAX_OUT, 2, max outstanding memory requests (1..DEPTH)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
redirect_valid  in  1  core requests fetch restart
redirect_pc  in  W  new fetch address
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  W  word address (byte address, [1:0]=0)
imem_rsp_valid  in  1  response data valid, in request order
imem_rsp_data  in  W  fetched instruction
inst_valid  out  1  FIFO head valid to core
inst_ready  in  1  core consumes head
inst_data  out  W  instruction at FIFO head
inst_pc  out  W  PC of inst_data
flushing  out  1  squashed responses still pending (drop_cnt != 0)

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0; imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, flushing=0.
- Issue: imem_req_valid=1 when !redirect_valid && outstanding<MAX_OUT && (outstanding-drop_cnt)+fifo_count<DEPTH. imem_req_addr=fetch_pc. On req_valid&&req_ready: fetch_pc+=4, outstanding+=1. req_valid may deassert without fire only through redirect or the credit condition.
- Response: every imem_rsp_valid decrements outstanding. If drop_cnt>0: discard, drop_cnt-=1. Else push {imem_rsp_data, rsp_pc} into FIFO, rsp_pc+=4. Credit check guarantees FIFO never overflows; overflow is a design error (assert in sim).
- Output: inst_valid = FIFO non-empty; inst_data/inst_pc from head, combinational from FIFO storage; pop on inst_valid&&inst_ready. Push and pop in same cycle allowed when full or empty (empty: data appears next cycle, no bypass). Latency: request fire to inst_valid is memory latency + 1 cycle.
- Redirect (priority over everything, same cycle): FIFO cleared, inst_valid=0 next cycle, no pop counted; fetch_pc=rsp_pc=redirect_pc with [1:0] forced to 0; drop_cnt = outstanding - (rsp_valid ? 1:0) (the response arriving this cycle is also discarded); no request issued this cycle. Redirect while flushing: same rule, drop_cnt recomputed from current outstanding.
- Counters are $clog2(MAX_OUT)+1 bits; outstanding never exceeds MAX_OUT, never underflows (rsp with outstanding=0 is an assert failure).
- Address arithmetic wraps modulo 2^W (0xFFFF_FFFC+4 = 0).

Optional Feature:
Macro FETCH_MISALIGN_EN. Defined: extra output port fetch_misalign (1 bit, reset 0), set sticky the cycle after a redirect with redirect_pc[1:0]!=0; cleared only by reset; address still masked. Undefined: port absent, low bits silently masked, no other change.

Test Plan:
- Reset release, memory 1-cycle latency, always ready, inst_ready=1 -> requests to 0x0,0x4,0x8...; inst_pc sequence 0x0,0x4,0x8 with matching data, one instruction per cycle sustained.
- inst_ready=0 held -> exactly DEPTH=4 words buffered (PCs 0x0..0xC), imem_req_valid low once credits exhausted; release -> 4 pops in 4 cycles, fetch resumes at 0x10.
- Memory latency 3, 2 requests outstanding, redirect_pc=0x100 -> both stale responses dropped, flushing=1 until second arrives, first delivered inst_pc=0x100.
- Redirect same cycle as imem_rsp_valid with outstanding=1 -> response dropped, drop_cnt=0, flushing stays 0, next request addr=0x100.
- rst asserted mid-stream with FIFO half full -> all outputs 0 immediately (async), after release first request addr=RESET_PC.
- FETCH_MISALIGN_EN defined, redirect_pc=0x102 -> fetch_misalign=1 next cycle and stays, request addr=0x100.
